// File: rtl/decode_stage_pipe.sv
// Pipelined decode stage: control decode, 16-entry register file with
// write-to-read bypass, immediate extension, load-use stall, ID/EX register.
//
// Ports:
//   clk, rst (sync, active-low)
//   in_valid/in_ready, instr_i, pc_i            fetch-side handshake
//   wb_en, wb_addr, wb_data                     register-file write port
//   flush                                       kill decoded/in-flight work
//   out_valid/out_ready, ex_*                   ID/EX register outputs
//   hazard_stall                                load-use stall indicator

module control_unit (
    input  logic [1:0] op,
    input  logic       sbit,
    input  logic [3:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       flag_w,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       mem_write,
    output logic       branch,
    output logic       alu_src,
    output logic       no_write,
    output logic       reg_src_a1,
    output logic       reg_src_a2
);
    // op 00: reg ALU, 01: load(sbit=1)/store(sbit=0),
    // op 10: branch (base is R15), op 11: imm ALU.
    // funct 1010 is a compare: flags only, no register write.
    always_comb begin
        alu_ctrl   = 4'h0;
        flag_w     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        alu_src    = 1'b0;
        no_write   = 1'b0;
        reg_src_a1 = 1'b0;
        reg_src_a2 = 1'b0;
        unique case (op)
            2'b00, 2'b11: begin
                alu_ctrl  = funct;
                flag_w    = sbit;
                no_write  = (funct == 4'b1010);
                reg_write = (funct != 4'b1010);
                alu_src   = op[0];
            end
            2'b01: begin
                alu_ctrl   = 4'b0100;
                alu_src    = 1'b1;
                reg_write  = sbit;
                mem_to_reg = sbit;
                mem_write  = ~sbit;
                reg_src_a2 = ~sbit;
            end
            2'b10: begin
                alu_ctrl   = 4'b0100;
                alu_src    = 1'b1;
                branch     = 1'b1;
                reg_src_a1 = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

module decode_stage_pipe #(
    parameter int XLEN      = 32,
    parameter int PC_OFFSET = 8,
    parameter int BYPASS    = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            wb_en,
    input  logic [3:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      ex_alu_ctrl,
    output logic [3:0]      ex_ra1,
    output logic [3:0]      ex_ra2,
    output logic [3:0]      ex_rd,
    output logic [XLEN-1:0] ex_rd1,
    output logic [XLEN-1:0] ex_rd2,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_pc,
    output logic            ex_flag_w,
    output logic            ex_reg_write,
    output logic            ex_mem_to_reg,
    output logic            ex_mem_write,
    output logic            ex_branch,
    output logic            ex_alu_src,
    output logic            ex_no_write,
    output logic            hazard_stall
);
    logic [3:0]      alu_ctrl;
    logic            flag_w, reg_write, mem_to_reg, mem_write;
    logic            branch, alu_src, no_write;
    logic            src_a1, src_a2;
    logic [3:0]      ra1, ra2, rd;
    logic [XLEN-1:0] rd1, rd2, imm, r15;
    logic [XLEN-1:0] rf [16];
    logic            accept;

    control_unit u_ctrl (
        .op         (instr_i[31:30]),
        .sbit       (instr_i[4]),
        .funct      (instr_i[3:0]),
        .alu_ctrl   (alu_ctrl),
        .flag_w     (flag_w),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .mem_write  (mem_write),
        .branch     (branch),
        .alu_src    (alu_src),
        .no_write   (no_write),
        .reg_src_a1 (src_a1),
        .reg_src_a2 (src_a2)
    );

    assign ra1 = src_a1 ? 4'hF : instr_i[25:22];
    assign ra2 = src_a2 ? instr_i[29:26] : instr_i[21:18];
    assign rd  = instr_i[29:26];
    assign imm = {{(XLEN-17){instr_i[21]}}, instr_i[21:5]};
    assign r15 = pc_i + XLEN'(PC_OFFSET);

    // R15 is never stored; it always reads as the PC plus offset, so a
    // write to it is dropped and can never be bypassed.
    always_comb begin
        rd1 = rf[ra1];
        rd2 = rf[ra2];
        if (BYPASS != 0 && wb_en && wb_addr == ra1) rd1 = wb_data;
        if (BYPASS != 0 && wb_en && wb_addr == ra2) rd2 = wb_data;
        if (ra1 == 4'hF) rd1 = r15;
        if (ra2 == 4'hF) rd2 = r15;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else if (wb_en && wb_addr != 4'hF) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // Conservative: compares both addresses even if an operand is unused.
    assign hazard_stall = in_valid & out_valid & ex_mem_to_reg
                        & ex_reg_write & (ex_rd != 4'hF)
                        & ((ex_rd == ra1) | (ex_rd == ra2));

    assign in_ready = ~hazard_stall & ~flush & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid     <= 1'b0;
            ex_alu_ctrl   <= '0;
            ex_ra1        <= '0;
            ex_ra2        <= '0;
            ex_rd         <= '0;
            ex_rd1        <= '0;
            ex_rd2        <= '0;
            ex_imm        <= '0;
            ex_pc         <= '0;
            ex_flag_w     <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_branch     <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_no_write   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            ex_alu_ctrl   <= alu_ctrl;
            ex_ra1        <= ra1;
            ex_ra2        <= ra2;
            ex_rd         <= rd;
            ex_rd1        <= rd1;
            ex_rd2        <= rd2;
            ex_imm        <= imm;
            ex_pc         <= pc_i;
            ex_flag_w     <= flag_w;
            ex_reg_write  <= reg_write;
            ex_mem_to_reg <= mem_to_reg;
            ex_mem_write  <= mem_write;
            ex_branch     <= branch;
            ex_alu_src    <= alu_src;
            ex_no_write   <= no_write;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Parametrised, pipelined successor of the single-cycle decode stage.
- Decodes one 32-bit instruction per transfer. Reads a 16-entry register file with write-to-read bypass. Sign-extends the 17-bit immediate to XLEN.
- Registers all results into an ID/EX pipeline register with valid/ready handshakes on both sides.
- Detects load-use hazards and inserts bubbles. Supports synchronous flush for taken branches.

Parameters:
- XLEN, 32, datapath width of registers, immediate, PC.
- PC_OFFSET, 8, value added to pc_i when R15 is read.
- BYPASS, 1, 1 = a same-cycle writeback to the read address returns wb_data; 0 = returns the old value.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- in_valid  in  1  fetch presents instr_i/pc_i.
- in_ready  out  1  decode accepts this cycle (combinational).
- instr_i  in  32  instruction word.
- pc_i  in  XLEN  PC of instr_i.
- wb_en  in  1  register-file write enable.
- wb_addr  in  4  write address.
- wb_data  in  XLEN  write data.
- flush  in  1  kill the decoded and in-flight instruction.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  execute consumes ID/EX this cycle.
- ex_alu_ctrl  out  4  registered ALU control.
- ex_ra1, ex_ra2, ex_rd  out  4 each  registered source and destination addresses.
- ex_rd1, ex_rd2, ex_imm, ex_pc  out  XLEN each  registered operands, extended immediate, PC.
- ex_flag_w, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_branch, ex_alu_src, ex_no_write  out  1 each  registered control.
- hazard_stall  out  1  load-use stall active (combinational).

Behaviour:
- Control decode: existing ControlUnit instance, unchanged encoding. Inputs are instr_i[4], instr_i[31:30] and instr_i[3:0].
- Register address selection:
  - ra1 = RegSrcA1 ? 4'hF : instr_i[25:22].
  - ra2 = RegSrcA2 ? instr_i[29:26] : instr_i[21:18].
  - rd = instr_i[29:26].
- Immediate: ex_imm = sign-extension of instr_i[21:5] (bit 21 is the sign) to XLEN.
- Register file: 16 x XLEN, written on clk when wb_en=1.
  - wb_en with wb_addr=15 is ignored.
  - Reading R15 returns pc_i + PC_OFFSET (mod 2^XLEN).
  - Read of the address being written with wb_en=1: returns wb_data when BYPASS=1; returns the old value when BYPASS=0.
- Hazard (combinational):
  - hazard_stall = in_valid & out_valid & ex_mem_to_reg & ex_reg_write & (ex_rd==ra1 | ex_rd==ra2) & ex_rd!=15.
  - The comparison is conservative: it applies whether or not the operand is used.
- in_ready = ~hazard_stall & ~flush & (~out_valid | out_ready).
- Accept = in_valid & in_ready: the ID/EX register loads all decoded fields and out_valid<=1.
- Stall with out_ready=1: out_valid<=0 (bubble). The instruction stays at the input and is retried the next cycle.
- out_valid=1 & out_ready=0: the ID/EX register holds all fields unchanged.
- out_ready=1 & no accept: out_valid<=0; data fields hold (don't-care).
- Flush: out_valid<=0 next cycle and the input is not accepted that cycle. A register-file write in the same cycle still happens.
- Priority: rst > flush > accept > bubble/drain > hold.
- Reset (rst=0 at clk edge): out_valid=0, all ex_* outputs 0, all 16 registers 0.
  - Reset mid-stream discards the ID/EX contents.
  - in_ready evaluates from the post-reset state the next cycle.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 instruction per cycle without hazards or backpressure.

Test Plan:
- Reset then write: rst=0 for 2 cycles, then wb_en=1, wb_addr=3, wb_data=0x0000_00AA. Next, decode an instruction with ra1=3 -> out_valid=1 one cycle after accept; ex_rd1=0x0000_00AA; all other registers read 0.
- Bypass: same cycle as wb_en=1, wb_addr=5, wb_data=0x1234, decode with ra2=5 -> ex_rd2=0x1234. Repeat with BYPASS=0 -> ex_rd2=old value 0.
- R15 and immediate: pc_i=0x100, ra1 forced to 15 by RegSrcA1, instr_i[21:5]=17'h1FFFF -> ex_rd1=0x108, ex_imm=0xFFFF_FFFF.
- Load-use: a load with rd=2 in ID/EX, out_ready=1; next instruction has ra1=2 -> hazard_stall=1, in_ready=0, bubble (out_valid=0) for 1 cycle. The instruction is accepted the following cycle.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles -> in_ready=0 and ex_* stable; out_ready=1 -> the next instruction is accepted the same cycle.
- Flush and reset mid-operation: flush=1 while in_valid=1 -> out_valid=0 next cycle, instruction dropped. rst=0 with out_valid=1 -> all ex_*=0 and out_valid=0 next cycle.
